ovl_fire_collector: RTL
=======================

Name: ovl_fire_collector

Overview:
- Receiving end of the checker fire interface: collects single-cycle fire pulses from up to NUM_CHECKERS assertion/assumption checkers.
- Latches per-checker sticky status, counts firing cycles, and queues timestamped fire events in a small FIFO.
- The FIFO drains to a downstream reporter/logger over a valid/ready handshake.
- Sits at the top of a verification harness, one instance per checker cluster.

Parameters:
- NUM_CHECKERS, 8, width of the fire vector; 1..32.
- TS_WIDTH, 16, width of the free-running cycle timestamp.
- DEPTH, 8, event FIFO entries; power of 2, minimum 2.
- CNT_WIDTH, 16, width of the saturating counters fire_cnt and drop_cnt.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  collection enable; when low, fire is ignored (no sticky, count or push).
- fire  input  NUM_CHECKERS  fire pulses, one bit per checker.
- clear  input  1  clears sticky and overflow.
- sticky  output  NUM_CHECKERS  per-checker "has fired" flags.
- any_fired  output  1  OR of sticky.
- fire_cnt  output  CNT_WIDTH  number of enabled cycles with fire != 0; saturating.
- drop_cnt  output  CNT_WIDTH  number of events dropped on a full FIFO; saturating.
- overflow  output  1  sticky flag; set when an event is dropped.
- evt_valid  output  1  FIFO not empty.
- evt_ready  input  1  downstream accepts the event.
- evt_ts  output  TS_WIDTH  timestamp of the head event.
- evt_fire  output  NUM_CHECKERS  fire vector of the head event.

Behaviour:
- Reset (synchronous, sampled on clk): all outputs, FIFO pointers, occupancy and the timestamp counter go to 0. evt_valid = 0 the cycle after reset is sampled. Reset mid-operation discards all queued events.
- Timestamp: ts increments every cycle while not in reset, regardless of enable, and wraps from 2^TS_WIDTH-1 to 0 silently.
- Event: ev = enable && (fire != 0), evaluated in cycle t.
  - Entry pushed is {ts value in cycle t, fire}.
  - The entry is visible at the FIFO head at t+1: one cycle of latency to evt_valid when the FIFO was empty.
- Handshake: pop occurs when evt_valid && evt_ready.
  - evt_ts and evt_fire stay stable while evt_valid && !evt_ready.
  - evt_ready while evt_valid = 0 has no effect.
- Full FIFO:
  - ev && full && !pop → event dropped; overflow set to 1; drop_cnt increments.
  - ev && full && pop → push accepted, no drop; occupancy unchanged.
- Empty FIFO with ev in the same cycle: no pop is possible (evt_valid = 0), so the push lands and evt_valid = 1 next cycle. There is no bypass.
- Sticky: sticky_next = (clear ? 0 : sticky) | (enable ? fire : 0). A fire in the same cycle as clear wins.
  - overflow: clear zeroes it; a drop in the same cycle as clear leaves overflow = 1.
  - clear does not affect the FIFO, fire_cnt or drop_cnt.
- Counters: fire_cnt increments by 1 per ev cycle, irrespective of the number of bits set or FIFO state. fire_cnt and drop_cnt stick at 2^CNT_WIDTH-1. Only reset zeroes them.
- Occupancy: tracked with DEPTH+1 states. Full = DEPTH entries, empty = 0. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: OVL_FIRE_COLLECTOR_XCHECK_EN.
- Defined:
  - adds output port xz_err (1 bit, reset 0).
  - Any X/Z bit on fire or enable while not in reset sets xz_err, sticky until reset.
  - In that cycle no push, sticky update or count is performed, and $display reports "OVL_FIRE_COLLECTOR: X/Z on fire" with the timestamp.
- Undefined: no xz_err port, no X/Z detection; X on fire propagates per normal simulation semantics.

Test Plan:
- Reset, then enable=1, fire=8'h04 at ts=5, evt_ready=0 → next cycle: evt_valid=1, evt_ts=5, evt_fire=8'h04, sticky=8'h04, any_fired=1, fire_cnt=1. Outputs stay stable until evt_ready=1 pops them, then evt_valid=0.
- evt_ready=0, fire=8'h01 for 10 consecutive cycles with DEPTH=8 → 8 entries queued with consecutive ts, drop_cnt=2, overflow=1, fire_cnt=10. Draining yields exactly the first 8 timestamps in order.
- FIFO full, evt_ready=1, fire=8'h80 in the same cycle → no drop (drop_cnt unchanged), occupancy stays 8, new entry is last in drain order.
- sticky=8'h03, clear=1 and fire=8'h10 in the same cycle → sticky=8'h10. With overflow=1 and clear=1 and no drop → overflow=0.
- enable=0, fire=8'hFF for 3 cycles → sticky, fire_cnt and evt_valid unchanged. Then reset asserted with 4 entries queued → evt_valid=0 and all counters 0 the next cycle.
- With OVL_FIRE_COLLECTOR_XCHECK_EN defined, fire=8'bxxxx_0000 for one cycle → xz_err=1, no FIFO entry, fire_cnt unchanged. xz_err clears only on reset.

Source files
------------

// File: rtl/ovl_fire_collector.sv
// Collects checker fire pulses into sticky flags, saturating counters and a timestamped event FIFO.
// Define OVL_FIRE_COLLECTOR_XCHECK_EN to add X/Z detection on fire/enable with the xz_err output.
module ovl_fire_collector #(
  parameter int unsigned NUM_CHECKERS = 8,
  parameter int unsigned TS_WIDTH     = 16,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CHECKERS-1:0] fire,
  input  logic                    clear,
  output logic [NUM_CHECKERS-1:0] sticky,
  output logic                    any_fired,
  output logic [CNT_WIDTH-1:0]    fire_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt,
  output logic                    overflow,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [TS_WIDTH-1:0]     evt_ts,
  output logic [NUM_CHECKERS-1:0] evt_fire
`ifdef OVL_FIRE_COLLECTOR_XCHECK_EN
  ,
  output logic                    xz_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = TS_WIDTH + NUM_CHECKERS;
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [TS_WIDTH-1:0]     ts_q;
  logic [NUM_CHECKERS-1:0] sticky_q, sticky_d;
  logic                    overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]    fire_cnt_q, drop_cnt_q;
  logic [EW-1:0]           mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             count_q, count_d;

  logic                    xz_now;
  logic                    ev, full, empty, push, pop, drop;
  logic [NUM_CHECKERS-1:0] fire_en;

`ifdef OVL_FIRE_COLLECTOR_XCHECK_EN
  logic xz_err_q;

  assign xz_now = $isunknown({enable, fire});
  assign xz_err = xz_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      xz_err_q <= 1'b0;
    end else if (xz_now) begin
      xz_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && xz_now) begin
      $display("OVL_FIRE_COLLECTOR: X/Z on fire at ts=%0d", ts_q);
    end
  end
`else
  assign xz_now = 1'b0;
`endif

  // A cycle with X/Z on the inputs is treated as if collection were disabled.
  assign fire_en = (enable && !xz_now) ? fire : '0;
  assign ev      = |fire_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);
  assign pop   = !empty && evt_ready;
  assign push  = ev && (!full || pop);
  assign drop  = ev && full && !pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    sticky_d   = (clear ? '0 : sticky_q) | fire_en;
    overflow_d = (clear ? 1'b0 : overflow_q) | drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q       <= '0;
      sticky_q   <= '0;
      overflow_q <= 1'b0;
      fire_cnt_q <= '0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_q      <= '{default: '0};
    end else begin
      ts_q       <= ts_q + TS_WIDTH'(1);
      sticky_q   <= sticky_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      if (ev && (fire_cnt_q != '1)) begin
        fire_cnt_q <= fire_cnt_q + CNT_WIDTH'(1);
      end
      if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
      end
      if (push) begin
        mem_q[wr_ptr_q] <= {ts_q, fire};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign sticky    = sticky_q;
  assign any_fired = |sticky_q;
  assign fire_cnt  = fire_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;
  assign evt_valid = !empty;
  assign {evt_ts, evt_fire} = mem_q[rd_ptr_q];

endmodule
